// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM states, forwarding
// selects and the hard-wired zero register index.
package riscv_pipe_pkg;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam int REG_ZERO = 0;

    // Number of operand forwarding comparators: rs1_ex, rs2_ex, rs2_mem.
    localparam int FWD_PORTS = 3;

endpackage : riscv_pipe_pkg

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave):
// stage register indices / control bits in, enables, flushes, forwarding and counters out.
interface hazard_ctrl_unit_if
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // ID stage
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic              uses_rs2_id;
    // EX stage
    logic [REG_AW-1:0] rd_ex;
    logic              memread_ex;
    logic [REG_AW-1:0] rs1_ex;
    logic [REG_AW-1:0] rs2_ex;
    // MEM stage
    logic [REG_AW-1:0] rd_mem;
    logic [REG_AW-1:0] rs2_mem;
    logic              regwrite_mem;
    logic              memread_mem;
    logic              memwrite_mem;
    logic              redirect_mem;
    // WB stage
    logic [REG_AW-1:0] rd_wb;
    logic              regwrite_wb;

    // Pipeline register control
    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              idex_bubble;
    logic              memwb_bubble;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    // Operand steering
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              fwd_store;
    // Performance counters
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output rs1_id, rs2_id, uses_rs2_id,
        output rd_ex, memread_ex, rs1_ex, rs2_ex,
        output rd_mem, rs2_mem, regwrite_mem, memread_mem, memwrite_mem, redirect_mem,
        output rd_wb, regwrite_wb,
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  idex_bubble, memwb_bubble,
        input  ifid_flush, idex_flush, exmem_flush,
        input  fwd_a, fwd_b, fwd_store,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  rs1_id, rs2_id, uses_rs2_id,
        input  rd_ex, memread_ex, rs1_ex, rs2_ex,
        input  rd_mem, rs2_mem, regwrite_mem, memread_mem, memwrite_mem, redirect_mem,
        input  rd_wb, regwrite_wb,
        output pc_write, ifid_write, idex_write, exmem_write,
        output idex_bubble, memwb_bubble,
        output ifid_flush, idex_flush, exmem_flush,
        output fwd_a, fwd_b, fwd_store,
        output stall_cycles, flush_events
    );

endinterface : hazard_ctrl_unit_if

// File: rtl/hazard_ctrl_unit_fwd.sv
// One forwarding comparator: picks the MEM result over the WB result for a source
// register, never forwarding into x0.
module fwd_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] rd_wb,
    output fwd_sel_t          sel
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && (rd_mem != ZERO_IDX) && (rd_mem == src);
    assign wb_hit  = wb_valid  && (rd_wb  != ZERO_IDX) && (rd_wb  == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_unit

// File: rtl/hazard_ctrl_unit.sv
// Stall / flush / forward controller for the 5-stage RV32I pipeline, including
// multi-cycle data-RAM wait states and saturating stall/flush counters.
module hazard_ctrl_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic            CLOCK,
    input  logic            RST_n,
    hazard_ctrl_unit_if.slave hz
);

    localparam int                CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]     LAT_M1   = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;
    localparam logic              HAS_LAT  = (MEM_LAT != 0);
    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

    hz_state_t        state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic mem_acc;
    logic mem_stall;
    logic load_use;
    logic redirect_act;
    logic load_use_act;

    // ---------------------------------------------------------------
    // Forwarding comparators: rs1_ex, rs2_ex and the store data in MEM
    // ---------------------------------------------------------------
    logic [REG_AW-1:0] fwd_src    [FWD_PORTS];
    logic              fwd_mem_ok [FWD_PORTS];
    fwd_sel_t          fwd_sel    [FWD_PORTS];

    assign fwd_src[0]    = hz.rs1_ex;
    assign fwd_src[1]    = hz.rs2_ex;
    assign fwd_src[2]    = hz.rs2_mem;
    // A load in MEM has no result yet; the store path only ever looks at WB.
    assign fwd_mem_ok[0] = hz.regwrite_mem & ~hz.memread_mem;
    assign fwd_mem_ok[1] = hz.regwrite_mem & ~hz.memread_mem;
    assign fwd_mem_ok[2] = 1'b0;

    generate
        for (genvar gi = 0; gi < FWD_PORTS; gi++) begin : g_fwd
            fwd_unit #(
                .REG_AW (REG_AW)
            ) u_fwd (
                .src       (fwd_src[gi]),
                .mem_valid (fwd_mem_ok[gi]),
                .rd_mem    (hz.rd_mem),
                .wb_valid  (hz.regwrite_wb),
                .rd_wb     (hz.rd_wb),
                .sel       (fwd_sel[gi])
            );
        end
    endgenerate

    assign hz.fwd_a     = fwd_sel[0];
    assign hz.fwd_b     = fwd_sel[1];
    assign hz.fwd_store = hz.memwrite_mem & (fwd_sel[2] == FWD_WB);

    // ---------------------------------------------------------------
    // Data-RAM wait-state FSM
    // ---------------------------------------------------------------
    assign mem_acc = hz.memread_mem | hz.memwrite_mem;

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_stall  = 1'b0;
        case (state_reg)
            HZ_RUN: begin
                if (mem_acc && HAS_LAT) begin
                    mem_stall  = 1'b1;
                    state_next = HZ_WAIT;
                    cnt_next   = LAT_M1;
                end
            end
            HZ_WAIT: begin
                // The cnt==0 cycle is the release: the pipe advances this cycle.
                if (cnt_reg != '0) begin
                    mem_stall = 1'b1;
                    cnt_next  = cnt_reg - 1'b1;
                end else begin
                    state_next = HZ_RUN;
                end
            end
            default: begin
                state_next = HZ_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Hazard priority: mem_stall > redirect > load_use
    // ---------------------------------------------------------------
    assign load_use = hz.memread_ex && (hz.rd_ex != ZERO_IDX) &&
                      ((hz.rd_ex == hz.rs1_id) || (hz.uses_rs2_id && (hz.rd_ex == hz.rs2_id)));

    assign redirect_act = ~mem_stall & hz.redirect_mem;
    assign load_use_act = ~mem_stall & ~hz.redirect_mem & load_use;

    always_comb begin
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_write   = 1'b1;
        hz.exmem_write  = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.memwb_bubble = 1'b0;
        hz.ifid_flush   = 1'b0;
        hz.idex_flush   = 1'b0;
        hz.exmem_flush  = 1'b0;
        if (mem_stall) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_write  = 1'b0;
            hz.memwb_bubble = 1'b1;
        end else if (redirect_act) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (load_use_act) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if ((mem_stall || load_use_act) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (redirect_act && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign hz.stall_cycles = stall_cnt_reg;
    assign hz.flush_events = flush_cnt_reg;

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a vector table on a single-cycle-RAM instance
// plus hand sequences for wait states, mid-wait reset and counter saturation.
module tb_hazard_ctrl_unit;
    import riscv_pipe_pkg::*;

    // {pc,ifid,idex,exmem write, idex_bubble, memwb_bubble, ifid,idex,exmem flush}
    localparam logic [8:0] CTL_RUN = 9'b1111_0_0_000;
    localparam logic [8:0] CTL_LU  = 9'b0011_1_0_000;
    localparam logic [8:0] CTL_RED = 9'b1111_0_0_111;
    localparam logic [8:0] CTL_MS  = 9'b0000_0_1_000;
    localparam int NVEC = 18;

    typedef struct {
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic       uses_rs2;
        logic [4:0] rd_ex;
        logic       mr_ex;
        logic [4:0] rs1_ex;
        logic [4:0] rs2_ex;
        logic [4:0] rd_mem;
        logic [4:0] rs2_mem;
        logic       rw_mem;
        logic       mr_mem;
        logic       mw_mem;
        logic [4:0] rd_wb;
        logic       rw_wb;
        logic       redir;
        logic [8:0] exp_ctl;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_st;
    } vec_t;

    logic CLOCK;
    logic rst_n_a, rst_n_b, rst_n_c;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NVEC];

    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) ifb ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  ifc ();

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(0), .CNT_W(16)) dut_a (.CLOCK(CLOCK), .RST_n(rst_n_a), .hz(ifa));
    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(16)) dut_b (.CLOCK(CLOCK), .RST_n(rst_n_b), .hz(ifb));
    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(4))  dut_c (.CLOCK(CLOCK), .RST_n(rst_n_c), .hz(ifc));

    logic [8:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {ifa.pc_write, ifa.ifid_write, ifa.idex_write, ifa.exmem_write, ifa.idex_bubble,
                    ifa.memwb_bubble, ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush};
    assign ctl_b = {ifb.pc_write, ifb.ifid_write, ifb.idex_write, ifb.exmem_write, ifb.idex_bubble,
                    ifb.memwb_bubble, ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush};
    assign ctl_c = {ifc.pc_write, ifc.ifid_write, ifc.idex_write, ifc.exmem_write, ifc.idex_bubble,
                    ifc.memwb_bubble, ifc.ifid_flush, ifc.idex_flush, ifc.exmem_flush};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic zero_all();
        ifa.rs1_id = '0; ifa.rs2_id = '0; ifa.uses_rs2_id = 1'b0; ifa.rd_ex = '0; ifa.memread_ex = 1'b0;
        ifa.rs1_ex = '0; ifa.rs2_ex = '0; ifa.rd_mem = '0; ifa.rs2_mem = '0; ifa.regwrite_mem = 1'b0;
        ifa.memread_mem = 1'b0; ifa.memwrite_mem = 1'b0; ifa.redirect_mem = 1'b0; ifa.rd_wb = '0;
        ifa.regwrite_wb = 1'b0;
        ifb.rs1_id = '0; ifb.rs2_id = '0; ifb.uses_rs2_id = 1'b0; ifb.rd_ex = '0; ifb.memread_ex = 1'b0;
        ifb.rs1_ex = '0; ifb.rs2_ex = '0; ifb.rd_mem = '0; ifb.rs2_mem = '0; ifb.regwrite_mem = 1'b0;
        ifb.memread_mem = 1'b0; ifb.memwrite_mem = 1'b0; ifb.redirect_mem = 1'b0; ifb.rd_wb = '0;
        ifb.regwrite_wb = 1'b0;
        ifc.rs1_id = '0; ifc.rs2_id = '0; ifc.uses_rs2_id = 1'b0; ifc.rd_ex = '0; ifc.memread_ex = 1'b0;
        ifc.rs1_ex = '0; ifc.rs2_ex = '0; ifc.rd_mem = '0; ifc.rs2_mem = '0; ifc.regwrite_mem = 1'b0;
        ifc.memread_mem = 1'b0; ifc.memwrite_mem = 1'b0; ifc.redirect_mem = 1'b0; ifc.rd_wb = '0;
        ifc.regwrite_wb = 1'b0;
    endtask

    task automatic apply_a(input vec_t v);
        ifa.rs1_id = v.rs1_id; ifa.rs2_id = v.rs2_id; ifa.uses_rs2_id = v.uses_rs2;
        ifa.rd_ex = v.rd_ex; ifa.memread_ex = v.mr_ex; ifa.rs1_ex = v.rs1_ex; ifa.rs2_ex = v.rs2_ex;
        ifa.rd_mem = v.rd_mem; ifa.rs2_mem = v.rs2_mem; ifa.regwrite_mem = v.rw_mem;
        ifa.memread_mem = v.mr_mem; ifa.memwrite_mem = v.mw_mem; ifa.rd_wb = v.rd_wb;
        ifa.regwrite_wb = v.rw_wb; ifa.redirect_mem = v.redir;
    endtask

    initial begin
        //          rs1id  rs2id  u     rdex   mrex  rs1ex  rs2ex  rdmem  rs2mem rwm   mrm   mwm   rdwb   rwwb  red   ctl      a      b      st
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_LU,  2'b00, 2'b00, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, CTL_RUN, 2'b01, 2'b00, 1'b0};
        vecs[3]  = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_LU,  2'b00, 2'b00, 1'b0};
        vecs[4]  = '{5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL_RED, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, CTL_RUN, 2'b10, 2'b10, 1'b0};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, CTL_RUN, 2'b01, 2'b01, 1'b0};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, CTL_RUN, 2'b10, 2'b01, 1'b0};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b1};
        vecs[14] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[15] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[16] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, CTL_RUN, 2'b00, 2'b00, 1'b0};
        vecs[17] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL_RED, 2'b00, 2'b00, 1'b0};

        // Reset state on all three instances
        zero_all();
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        repeat (2) @(negedge CLOCK);
        #1;
        chk("rst_ctl_a", 32'(ctl_a), 32'(CTL_RUN));
        chk("rst_ctl_b", 32'(ctl_b), 32'(CTL_RUN));
        chk("rst_ctl_c", 32'(ctl_c), 32'(CTL_RUN));
        chk("rst_fwd_a", 32'({ifa.fwd_a, ifa.fwd_b, ifa.fwd_store}), 32'd0);
        chk("rst_stall_b", 32'(ifb.stall_cycles), 32'd0);
        chk("rst_flush_b", 32'(ifb.flush_events), 32'd0);
        @(negedge CLOCK);
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        $display("reset released at %0t", $time);

        // Vector table on the single-cycle-RAM instance
        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLOCK);
            apply_a(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].exp_ctl));
            chk($sformatf("vec%0d_fwd_a", i), 32'(ifa.fwd_a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_fwd_b", i), 32'(ifa.fwd_b), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_fwd_store", i), 32'(ifa.fwd_store), 32'(vecs[i].exp_st));
            $display("vec %0d: ctl=%b fwd_a=%b fwd_b=%b fwd_store=%b", i, ctl_a, ifa.fwd_a, ifa.fwd_b, ifa.fwd_store);
        end
        @(negedge CLOCK);
        zero_all();
        #1;
        chk("a_stall_cycles", 32'(ifa.stall_cycles), 32'd2);
        chk("a_flush_events", 32'(ifa.flush_events), 32'd2);
        $display("dut_a counters: stall=%0d flush=%0d", ifa.stall_cycles, ifa.flush_events);

        // MEM_LAT=3: three frozen cycles, redirect/load_use ignored then honoured on release
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            if (i == 0) begin
                ifb.memread_mem = 1'b1; ifb.rd_mem = 5'd5; ifb.regwrite_mem = 1'b1;
            end
            if (i == 1) begin
                ifb.redirect_mem = 1'b1; ifb.rd_ex = 5'd6; ifb.memread_ex = 1'b1; ifb.rs1_id = 5'd6;
            end
            #1;
            if (i < 3) begin
                chk($sformatf("b_stall%0d", i), 32'(ctl_b), 32'(CTL_MS));
            end else begin
                chk("b_release_ctl", 32'(ctl_b), 32'(CTL_RED));
                chk("b_stall_cnt3", 32'(ifb.stall_cycles), 32'd3);
                chk("b_flush_pre", 32'(ifb.flush_events), 32'd0);
            end
            $display("dut_b cycle %0d: ctl=%b stall=%0d", i, ctl_b, ifb.stall_cycles);
        end
        // Back-to-back store re-enters the wait immediately
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            if (i == 0) begin
                ifb.redirect_mem = 1'b0; ifb.memread_ex = 1'b0; ifb.rd_ex = '0; ifb.rs1_id = '0;
                ifb.memread_mem = 1'b0; ifb.regwrite_mem = 1'b0; ifb.memwrite_mem = 1'b1;
            end
            #1;
            if (i == 0) chk("b_flush_post", 32'(ifb.flush_events), 32'd1);
            if (i < 3) begin
                chk($sformatf("b2_stall%0d", i), 32'(ctl_b), 32'(CTL_MS));
            end else begin
                chk("b2_release_ctl", 32'(ctl_b), 32'(CTL_RUN));
                chk("b_stall_cnt6", 32'(ifb.stall_cycles), 32'd6);
            end
            $display("dut_b store cycle %0d: ctl=%b stall=%0d", i, ctl_b, ifb.stall_cycles);
        end
        @(negedge CLOCK);
        ifb.memwrite_mem = 1'b0;

        // MEM_LAT=4: asynchronous reset in the middle of the wait
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            if (i == 0) ifc.memread_mem = 1'b1;
            #1;
            chk($sformatf("c_stall%0d", i), 32'(ctl_c), 32'(CTL_MS));
        end
        chk("c_stall_cnt_pre", 32'(ifc.stall_cycles), 32'd2);
        #2;
        ifc.memread_mem = 1'b0;
        rst_n_c = 1'b0;
        #1;
        chk("c_async_rst_ctl", 32'(ctl_c), 32'(CTL_RUN));
        chk("c_async_rst_cnt", 32'(ifc.stall_cycles), 32'd0);
        $display("dut_c reset mid-wait: ctl=%b stall=%0d", ctl_c, ifc.stall_cycles);
        @(negedge CLOCK);
        rst_n_c = 1'b1;
        // Fresh access after reset: exactly four stalls from RUN
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            if (i == 0) ifc.memread_mem = 1'b1;
            #1;
            if (i < 4) begin
                chk($sformatf("c2_stall%0d", i), 32'(ctl_c), 32'(CTL_MS));
            end else begin
                chk("c2_release_ctl", 32'(ctl_c), 32'(CTL_RUN));
                chk("c2_stall_cnt4", 32'(ifc.stall_cycles), 32'd4);
            end
        end
        // Sixteen more load-use stalls: 20 total saturates a 4-bit counter at 15
        @(negedge CLOCK);
        ifc.memread_mem = 1'b0; ifc.rd_ex = 5'd5; ifc.memread_ex = 1'b1; ifc.rs1_id = 5'd5;
        #1;
        chk("c_lu_ctl", 32'(ctl_c), 32'(CTL_LU));
        repeat (10) @(negedge CLOCK);
        #1;
        chk("c_stall_cnt14", 32'(ifc.stall_cycles), 32'd14);
        repeat (6) @(negedge CLOCK);
        #1;
        chk("c_stall_sat", 32'(ifc.stall_cycles), 32'd15);
        $display("dut_c saturated stall=%0d", ifc.stall_cycles);
        @(negedge CLOCK);
        zero_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl_unit
